irq_or_agg: RTL and testbench
=============================

Name: irq_or_agg

Overview:
- Parametrised, registered N-input OR aggregator. It is the sequential successor to the 2-input OR gate.
- Captures per-channel events (level or rising-edge) into sticky pending bits with write-1-to-clear. Masks them and ORs them into one registered summary output.
- Counts summary assertions in a saturating counter.
- Sits between peripheral status lines and a single interrupt/flag consumer.

Parameters:
- N_IN, 8, number of input channels (1..32)
- EDGE_MODE, 0, 0 = capture on level high, 1 = capture on rising edge of each input
- STICKY, 1, 1 = pending bits hold until cleared; 0 = pending mirrors the current event each cycle, clr ignored
- CNT_W, 8, width of the summary-assertion counter

Ports:
- clk, input, 1, single clock, rising edge
- rst, input, 1, synchronous, active-high reset
- in_vec, input, N_IN, raw channel inputs, already synchronous to clk
- mask, input, N_IN, 1 = channel contributes to y
- clr, input, N_IN, write-1-to-clear pending bits (STICKY=1 only)
- cnt_clr, input, 1, synchronous clear of evt_cnt
- pending, output, N_IN, registered per-channel pending bits
- y, output, 1, registered OR of (pending & mask)
- y_pulse, output, 1, one-cycle pulse on y 0->1
- evt_cnt, output, CNT_W, saturating count of y rising transitions

Behaviour:
- Reset (rst=1 at an edge): in_q, pending, y, y_pulse and evt_cnt all go to 0. Reset has priority over every other input.
- in_q <= in_vec on every edge (previous-sample register).
- Event per channel:
  - EDGE_MODE=0: evt = in_vec.
  - EDGE_MODE=1: evt = in_vec & ~in_q.
- Pending update:
  - STICKY=1: pending <= (pending & ~clr) | evt.
  - Set wins over clear in the same cycle.
  - STICKY=0: pending <= evt.
- Summary: y <= |(pending & mask). This uses the registered pending value, so y lags pending by one edge.
- Latency: input high sampled at edge n gives pending=1 after edge n and y=1 after edge n+1.
- mask affects only y, never capture. Unmasking an already-pending channel raises y at the next edge. Masking it drops y at the next edge, provided no other unmasked bit is pending.
- y_pulse <= (|(pending & mask)) & ~y. It is high for exactly one cycle, coincident with the first cycle y=1.
- evt_cnt:
  - Increments by 1 in the same edge that sets y_pulse.
  - Saturates at 2^CNT_W-1 and never wraps.
- cnt_clr has priority:
  - cnt_clr with a simultaneous increment gives evt_cnt=1, so the event is not lost.
  - cnt_clr alone gives 0.
- Edge mode after reset: in_q=0, so an input held high across rst deassertion registers one edge event on the first active edge. This is intended.
- Edge mode with an input held high: only one event. The input must return low for at least one sampled edge before a new event is captured.
- Unused clr bits in STICKY=0 are ignored. pending then equals the registered event vector.

Decomposition:
- Package irq_or_pkg holds:
  - defaults N_IN_DEF=8 and CNT_W_DEF=8;
  - localparam MODE_LEVEL=0 and MODE_EDGE=1;
  - function sat_inc(cnt), which saturating-increments a CNT_W value.
- Sub-module irq_or_chan: a one-channel cell with in_q, evt detect and the sticky pending bit, with ports clk, rst, in_bit, clr_bit, pending_bit.
  - The top instantiates N_IN copies via generate.
  - The top performs the mask-AND, the OR-reduction, the y/y_pulse registers and the counter.

Test Plan:
1. Reset/level (N_IN=8, EDGE_MODE=0, STICKY=1):
   - Stimulus: hold rst 2 cycles, then in_vec=8'h04 for one cycle, mask=8'hFF.
   - Response: all outputs 0 during rst; pending=8'h04 after edge n; y=1 and y_pulse=1 after edge n+1; y_pulse=0 after edge n+2; evt_cnt=1; pending stays 8'h04 after the input drops.
2. Clear vs set:
   - Stimulus: pending=8'h04; assert clr=8'h04 with in_vec=0. Later assert clr=8'h04 and in_vec=8'h04 together.
   - Response: first case gives pending=0 and y=0 one edge later. Second case gives pending stays 8'h04 (set wins).
3. Mask:
   - Stimulus: mask=8'h00, in_vec pulse on bit 7.
   - Response: pending=8'h80, y=0, evt_cnt unchanged. Then mask=8'h80 gives y=1 next edge, y_pulse for one cycle, evt_cnt+1.
4. Edge mode (EDGE_MODE=1):
   - Stimulus: hold in_vec[0]=1 for 5 cycles, low 1 cycle, high again.
   - Response: exactly two pending sets; with clr=8'h01 between them, y_pulse fires twice and evt_cnt=2.
   - Also: input held high through rst deassertion gives one event on the first edge.
5. Counter (CNT_W=2):
   - Stimulus: generate 5 y rising transitions.
   - Response: evt_cnt goes 1,2,3,3,3.
   - Then cnt_clr together with a y rising gives evt_cnt=1; cnt_clr alone gives 0.
6. Non-sticky (STICKY=0):
   - Stimulus: in_vec=8'h10 for 1 cycle with clr=8'hFF.
   - Response: pending=8'h10 for exactly one cycle, then 0. y high for one cycle, one edge later.
   - Also: rst asserted mid-stream clears pending, y and evt_cnt on the same edge.

Source files
------------

// File: rtl/irq_or_agg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_or_pkg
//  Description : Shared constants and helpers for the registered N-input OR
//                aggregator (irq_or_agg) and its per-channel cell.
//                - N_IN_DEF / CNT_W_DEF : default channel count / counter width
//                - MODE_LEVEL / MODE_EDGE : capture-mode selector values
//                - sat_inc()            : saturating increment helper
//  Revision    : 1.0 - initial release
// ============================================================================
package irq_or_pkg;

  // Default sizing used when a parent does not override the parameters.
  localparam int N_IN_DEF  = 8;
  localparam int CNT_W_DEF = 8;

  // Capture-mode selector values for EDGE_MODE.
  localparam int MODE_LEVEL = 0;
  localparam int MODE_EDGE  = 1;

  // Widest counter the helper below can serve; CNT_W must not exceed it.
  localparam int CNT_W_MAX = 32;

  // Saturating increment. The caller zero-extends its CNT_W-bit count to
  // CNT_W_MAX bits and passes the all-ones value of its own width as max_val,
  // then casts the result back to CNT_W bits. The result never exceeds
  // max_val, so the truncation back to CNT_W loses nothing.
  function automatic logic [CNT_W_MAX-1:0] sat_inc(
    input logic [CNT_W_MAX-1:0] cnt,
    input logic [CNT_W_MAX-1:0] max_val
  );
    if (cnt >= max_val) begin
      return max_val;
    end
    return cnt + 32'd1;
  endfunction

endpackage : irq_or_pkg
`default_nettype wire

// File: rtl/irq_or_agg_if.sv
`default_nettype none
// ============================================================================
//  Module      : irq_or_agg_if
//  Description : Bundle of the channel-side and result-side signals of the
//                OR aggregator.
//                  in_vec  [N_IN]  raw channel inputs (already synchronous)
//                  mask    [N_IN]  1 = channel contributes to y
//                  clr     [N_IN]  write-1-to-clear of pending bits
//                  cnt_clr         synchronous clear of evt_cnt
//                  pending [N_IN]  registered per-channel pending bits
//                  y               registered OR of (pending & mask)
//                  y_pulse         one-cycle pulse on y 0->1
//                  evt_cnt [CNT_W] saturating count of y rising transitions
//                master : the agent driving channels/controls (e.g. a bench)
//                slave  : the aggregator itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface irq_or_agg_if
  import irq_or_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic [N_IN-1:0]  in_vec;
  logic [N_IN-1:0]  mask;
  logic [N_IN-1:0]  clr;
  logic             cnt_clr;
  logic [N_IN-1:0]  pending;
  logic             y;
  logic             y_pulse;
  logic [CNT_W-1:0] evt_cnt;

  modport master (
    output in_vec,
    output mask,
    output clr,
    output cnt_clr,
    input  pending,
    input  y,
    input  y_pulse,
    input  evt_cnt
  );

  modport slave (
    input  in_vec,
    input  mask,
    input  clr,
    input  cnt_clr,
    output pending,
    output y,
    output y_pulse,
    output evt_cnt
  );

endinterface : irq_or_agg_if
`default_nettype wire

// File: rtl/irq_or_agg_chan.sv
`default_nettype none
// ============================================================================
//  Module      : irq_or_chan
//  Description : One channel of the OR aggregator: previous-sample register,
//                event detection (level or rising edge) and the pending bit.
//                  clk         rising-edge clock
//                  rst         synchronous active-high reset
//                  in_bit      raw channel input, synchronous to clk
//                  clr_bit     write-1-to-clear of the pending bit
//                  pending_bit registered pending bit
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_or_chan
  import irq_or_pkg::*;
#(
  parameter int EDGE_MODE = MODE_LEVEL,  // MODE_LEVEL or MODE_EDGE
  parameter int STICKY    = 1            // 1 = hold until cleared
) (
  input  logic clk,
  input  logic rst,
  input  logic in_bit,
  input  logic clr_bit,
  output logic pending_bit
);

  logic r_in_q;     // input as sampled at the previous edge
  logic r_pending;
  logic w_evt;
  logic w_hold;     // part of the old pending bit that survives this edge

  // In edge mode only a 0->1 step between consecutive samples is an event,
  // so an input held high produces a single event. r_in_q resets to 0, which
  // makes an input held high across reset release count as one edge.
  assign w_evt = (EDGE_MODE == MODE_EDGE) ? (in_bit & ~r_in_q) : in_bit;

  // Sticky: keep the bit unless cleared this edge. The event is OR-ed in
  // afterwards, so a set and clear on the same edge leave the bit set.
  // Non-sticky: nothing is held and clr_bit has no effect.
  assign w_hold = (STICKY != 0) ? (r_pending & ~clr_bit) : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_q    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_in_q    <= in_bit;
      r_pending <= w_hold | w_evt;
    end
  end

  assign pending_bit = r_pending;

endmodule : irq_or_chan
`default_nettype wire

// File: rtl/irq_or_agg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_or_agg
//  Description : Registered N-input OR aggregator. Per-channel events are
//                captured into pending bits, masked, OR-reduced into a
//                registered summary y, edge-detected into y_pulse, and the
//                y rising transitions are counted in a saturating counter.
//                  clk  rising-edge clock
//                  rst  synchronous active-high reset (highest priority)
//                  bus  irq_or_agg_if.slave: in_vec, mask, clr, cnt_clr in;
//                       pending, y, y_pulse, evt_cnt out
//                The interface instance must be sized with the same N_IN and
//                CNT_W as this module. CNT_W is limited to 1..CNT_W_MAX.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_or_agg
  import irq_or_pkg::*;
#(
  parameter int N_IN      = N_IN_DEF,   // 1..32 channels
  parameter int EDGE_MODE = MODE_LEVEL, // MODE_LEVEL or MODE_EDGE
  parameter int STICKY    = 1,          // 1 = sticky pending bits
  parameter int CNT_W     = CNT_W_DEF   // evt_cnt width, 1..CNT_W_MAX
) (
  input  logic               clk,
  input  logic               rst,
  irq_or_agg_if.slave        bus
);

  // All-ones value of a CNT_W-bit counter, held in the helper's wide format.
  localparam logic [CNT_W_MAX-1:0] c_cnt_max =
    {CNT_W_MAX{1'b1}} >> (CNT_W_MAX - CNT_W);

  logic [N_IN-1:0]  w_pending;
  logic             w_any;      // some unmasked channel is pending now
  logic             w_rise;     // y is about to go 0->1
  logic             r_y;
  logic             r_y_pulse;
  logic [CNT_W-1:0] r_cnt;

  // --------------------------------------------------------------------------
  // Channel cells: capture and pending storage. Masking is deliberately kept
  // out of the cells so that a masked channel still records its events.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_chan
    irq_or_chan #(
      .EDGE_MODE (EDGE_MODE),
      .STICKY    (STICKY)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .in_bit      (bus.in_vec[gi]),
      .clr_bit     (bus.clr[gi]),
      .pending_bit (w_pending[gi])
    );
  end : g_chan

  // The summary works from the registered pending bits, so y trails pending
  // by one edge, while a mask change takes effect on the very next edge.
  assign w_any  = |(w_pending & bus.mask);
  assign w_rise = w_any & ~r_y;

  // --------------------------------------------------------------------------
  // Summary, pulse and assertion counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y       <= 1'b0;
      r_y_pulse <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_y       <= w_any;
      r_y_pulse <= w_rise;
      if (bus.cnt_clr) begin
        // A clear that coincides with a new assertion restarts the count at
        // one, so that assertion is not lost.
        r_cnt <= w_rise ? CNT_W'(1) : '0;
      end else if (w_rise) begin
        r_cnt <= CNT_W'(sat_inc(CNT_W_MAX'(r_cnt), c_cnt_max));
      end
    end
  end

  assign bus.pending = w_pending;
  assign bus.y       = r_y;
  assign bus.y_pulse = r_y_pulse;
  assign bus.evt_cnt = r_cnt;

endmodule : irq_or_agg
`default_nettype wire

// File: tb/tb_irq_or_agg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_or_agg
//  Description : Self-checking bench for irq_or_agg. Four instances with
//                different configurations share one stimulus stream:
//                  0: level, sticky, CNT_W=8
//                  1: edge,  sticky, CNT_W=8
//                  2: level, sticky, CNT_W=2
//                  3: level, non-sticky, CNT_W=8
//                A behavioural model per configuration is compared against
//                every instance on each falling edge; directed scenarios add
//                hand-computed literal expectations, followed by random
//                traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_or_agg;
  import irq_or_pkg::*;

  localparam int NK = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_in = 8'h00;
  logic [7:0] s_mask = 8'h00;
  logic [7:0] s_clr = 8'h00;
  logic       s_cnt_clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Interfaces and DUTs
  // --------------------------------------------------------------------------
  irq_or_agg_if #(.N_IN(8), .CNT_W(8)) if_a ();
  irq_or_agg_if #(.N_IN(8), .CNT_W(8)) if_b ();
  irq_or_agg_if #(.N_IN(8), .CNT_W(2)) if_c ();
  irq_or_agg_if #(.N_IN(8), .CNT_W(8)) if_d ();

  assign if_a.in_vec = s_in;  assign if_a.mask = s_mask;
  assign if_a.clr    = s_clr; assign if_a.cnt_clr = s_cnt_clr;
  assign if_b.in_vec = s_in;  assign if_b.mask = s_mask;
  assign if_b.clr    = s_clr; assign if_b.cnt_clr = s_cnt_clr;
  assign if_c.in_vec = s_in;  assign if_c.mask = s_mask;
  assign if_c.clr    = s_clr; assign if_c.cnt_clr = s_cnt_clr;
  assign if_d.in_vec = s_in;  assign if_d.mask = s_mask;
  assign if_d.clr    = s_clr; assign if_d.cnt_clr = s_cnt_clr;

  irq_or_agg #(.N_IN(8), .EDGE_MODE(MODE_LEVEL), .STICKY(1), .CNT_W(8))
    u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  irq_or_agg #(.N_IN(8), .EDGE_MODE(MODE_EDGE), .STICKY(1), .CNT_W(8))
    u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  irq_or_agg #(.N_IN(8), .EDGE_MODE(MODE_LEVEL), .STICKY(1), .CNT_W(2))
    u_c (.clk(clk), .rst(rst), .bus(if_c.slave));
  irq_or_agg #(.N_IN(8), .EDGE_MODE(MODE_LEVEL), .STICKY(0), .CNT_W(8))
    u_d (.clk(clk), .rst(rst), .bus(if_d.slave));

  logic [7:0] d_pend [NK];
  logic       d_y    [NK];
  logic       d_yp   [NK];
  logic [7:0] d_cnt  [NK];

  assign d_pend[0] = if_a.pending; assign d_y[0] = if_a.y;
  assign d_yp[0] = if_a.y_pulse;   assign d_cnt[0] = if_a.evt_cnt;
  assign d_pend[1] = if_b.pending; assign d_y[1] = if_b.y;
  assign d_yp[1] = if_b.y_pulse;   assign d_cnt[1] = if_b.evt_cnt;
  assign d_pend[2] = if_c.pending; assign d_y[2] = if_c.y;
  assign d_yp[2] = if_c.y_pulse;   assign d_cnt[2] = {6'd0, if_c.evt_cnt};
  assign d_pend[3] = if_d.pending; assign d_y[3] = if_d.y;
  assign d_yp[3] = if_d.y_pulse;   assign d_cnt[3] = if_d.evt_cnt;

  // --------------------------------------------------------------------------
  // Behavioural model: per configuration, what each output must be after an
  // edge, from the rules of the block (counter held as a plain integer).
  // --------------------------------------------------------------------------
  int         cfg_edge   [NK] = '{0, 1, 0, 0};
  int         cfg_sticky [NK] = '{1, 1, 1, 0};
  int         cfg_max    [NK] = '{255, 255, 3, 255};

  logic [7:0] m_last [NK];   // previous input sample
  logic [7:0] m_pend [NK];
  bit         m_y    [NK];
  bit         m_yp   [NK];
  int         m_cnt  [NK];
  bit         m_valid = 1'b0;

  logic [7:0] m_evt;
  bit         m_any;
  bit         m_rise;

  always @(posedge clk) begin
    for (int k = 0; k < NK; k++) begin
      if (rst) begin
        m_last[k] = 8'h00;
        m_pend[k] = 8'h00;
        m_y[k]    = 1'b0;
        m_yp[k]   = 1'b0;
        m_cnt[k]  = 0;
      end else begin
        m_evt  = (cfg_edge[k] != 0) ? (s_in & ~m_last[k]) : s_in;
        m_any  = ((m_pend[k] & s_mask) != 8'h00);
        m_rise = m_any && !m_y[k];
        m_pend[k] = (cfg_sticky[k] != 0) ? ((m_pend[k] & ~s_clr) | m_evt) : m_evt;
        m_yp[k] = m_rise;
        m_y[k]  = m_any;
        if (s_cnt_clr)
          m_cnt[k] = m_rise ? 1 : 0;
        else if (m_rise)
          m_cnt[k] = (m_cnt[k] + 1 > cfg_max[k]) ? cfg_max[k] : m_cnt[k] + 1;
        m_last[k] = s_in;
      end
    end
    if (rst) m_valid = 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Compare process: every falling edge, every instance against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < NK; k++) begin
        chk($sformatf("cyc_pending[%0d]", k), 32'(d_pend[k]), 32'(m_pend[k]));
        chk($sformatf("cyc_y[%0d]", k),       32'(d_y[k]),    32'(m_y[k]));
        chk($sformatf("cyc_y_pulse[%0d]", k), 32'(d_yp[k]),   32'(m_yp[k]));
        chk($sformatf("cyc_evt_cnt[%0d]", k), 32'(d_cnt[k]),  32'(m_cnt[k]));
      end
    end
  end

  // One clock of stimulus; returns 1 time unit after the consuming edge.
  task automatic cyc(input logic [7:0] i, input logic [7:0] m, input logic [7:0] c,
                     input logic cc, input logic r);
    @(negedge clk);
    #2;
    s_in = i; s_mask = m; s_clr = c; s_cnt_clr = cc; rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- 1: reset and level capture (instance 0) ----
    cyc(8'h00, 8'hFF, 8'h00, 1'b0, 1'b1);
    cyc(8'h00, 8'hFF, 8'h00, 1'b0, 1'b1);
    chk("rst_pending", 32'(if_a.pending), 32'h00);
    chk("rst_y",       32'(if_a.y),       32'h0);
    chk("rst_y_pulse", 32'(if_a.y_pulse), 32'h0);
    chk("rst_evt_cnt", 32'(if_a.evt_cnt), 32'h0);

    cyc(8'h04, 8'hFF, 8'h00, 1'b0, 1'b0);
    chk("lvl_pending_n", 32'(if_a.pending), 32'h04);
    chk("lvl_y_n",       32'(if_a.y),       32'h0);
    chk("model_pend_n",  32'(m_pend[0]),    32'h04);
    cyc(8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
    chk("lvl_y_n1",       32'(if_a.y),       32'h1);
    chk("lvl_y_pulse_n1", 32'(if_a.y_pulse), 32'h1);
    chk("lvl_evt_cnt_n1", 32'(if_a.evt_cnt), 32'h1);
    cyc(8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
    chk("lvl_y_pulse_n2", 32'(if_a.y_pulse), 32'h0);
    chk("lvl_pending_hold", 32'(if_a.pending), 32'h04);

    // ---- 2: clear vs set ----
    cyc(8'h00, 8'hFF, 8'h04, 1'b0, 1'b0);
    chk("clr_pending", 32'(if_a.pending), 32'h00);
    cyc(8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
    chk("clr_y_next", 32'(if_a.y), 32'h0);
    cyc(8'h04, 8'hFF, 8'h00, 1'b0, 1'b0);
    cyc(8'h04, 8'hFF, 8'h04, 1'b0, 1'b0);
    chk("set_wins_pending", 32'(if_a.pending), 32'h04);
    chk("set_wins_cnt",     32'(if_a.evt_cnt), 32'h2);
    cyc(8'h00, 8'hFF, 8'h04, 1'b0, 1'b0);
    cyc(8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);

    // ---- 3: mask ----
    cyc(8'h80, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("mask_pending", 32'(if_a.pending), 32'h80);
    cyc(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("mask_y_low",   32'(if_a.y),       32'h0);
    chk("mask_cnt_hold", 32'(if_a.evt_cnt), 32'h2);
    cyc(8'h00, 8'h80, 8'h00, 1'b0, 1'b0);
    chk("unmask_y",       32'(if_a.y),       32'h1);
    chk("unmask_y_pulse", 32'(if_a.y_pulse), 32'h1);
    chk("unmask_cnt",     32'(if_a.evt_cnt), 32'h3);
    chk("model_cnt_unmask", 32'(m_cnt[0]),   32'h3);
    cyc(8'h00, 8'h80, 8'h00, 1'b0, 1'b0);
    chk("unmask_pulse_end", 32'(if_a.y_pulse), 32'h0);
    cyc(8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0);
    cyc(8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);

    // ---- 4: edge mode (instance 1), input held high through reset ----
    cyc(8'h01, 8'hFF, 8'h00, 1'b0, 1'b1);
    chk("edge_rst_pending", 32'(if_b.pending), 32'h00);
    cyc(8'h01, 8'hFF, 8'h00, 1'b0, 1'b0);
    chk("edge_first_event", 32'(if_b.pending), 32'h01);
    cyc(8'h01, 8'hFF, 8'h00, 1'b0, 1'b0);
    chk("edge_pulse1", 32'(if_b.y_pulse), 32'h1);
    chk("edge_cnt1",   32'(if_b.evt_cnt), 32'h1);
    cyc(8'h01, 8'hFF, 8'h00, 1'b0, 1'b0);
    cyc(8'h01, 8'hFF, 8'h01, 1'b0, 1'b0);
    chk("edge_cleared", 32'(if_b.pending), 32'h00);
    cyc(8'h01, 8'hFF, 8'h00, 1'b0, 1'b0);
    chk("edge_held_no_event", 32'(if_b.pending), 32'h00);
    cyc(8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
    cyc(8'h01, 8'hFF, 8'h00, 1'b0, 1'b0);
    chk("edge_second_event", 32'(if_b.pending), 32'h01);
    cyc(8'h01, 8'hFF, 8'h00, 1'b0, 1'b0);
    chk("edge_pulse2", 32'(if_b.y_pulse), 32'h1);
    chk("edge_cnt2",   32'(if_b.evt_cnt), 32'h2);
    chk("model_edge_cnt2", 32'(m_cnt[1]), 32'h2);

    // ---- 5: saturating counter (instance 2, CNT_W=2) ----
    cyc(8'h00, 8'hFF, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(8'h01, 8'hFF, 8'h00, 1'b0, 1'b0);
      cyc(8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
      chk($sformatf("sat_cnt_%0d", i), 32'(if_c.evt_cnt), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
      cyc(8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0);
      cyc(8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
    end
    chk("model_sat_cnt", 32'(m_cnt[2]), 32'h3);
    cyc(8'h01, 8'hFF, 8'h00, 1'b0, 1'b0);
    cyc(8'h00, 8'hFF, 8'h00, 1'b1, 1'b0);
    chk("cnt_clr_with_rise", 32'(if_c.evt_cnt), 32'h1);
    chk("cnt_clr_rise_pulse", 32'(if_c.y_pulse), 32'h1);
    cyc(8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0);
    cyc(8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
    cyc(8'h00, 8'hFF, 8'h00, 1'b1, 1'b0);
    chk("cnt_clr_alone", 32'(if_c.evt_cnt), 32'h0);

    // ---- 6: non-sticky (instance 3) and mid-stream reset ----
    cyc(8'h00, 8'hFF, 8'h00, 1'b0, 1'b1);
    cyc(8'h10, 8'hFF, 8'hFF, 1'b0, 1'b0);
    chk("ns_pending", 32'(if_d.pending), 32'h10);
    chk("ns_y_lag",   32'(if_d.y),       32'h0);
    cyc(8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
    chk("ns_pending_gone", 32'(if_d.pending), 32'h00);
    chk("ns_y_high",       32'(if_d.y),       32'h1);
    cyc(8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
    chk("ns_y_low", 32'(if_d.y), 32'h0);
    cyc(8'h10, 8'hFF, 8'h00, 1'b0, 1'b0);
    cyc(8'h10, 8'hFF, 8'h00, 1'b0, 1'b0);
    chk("ns_cnt_before_rst", 32'(if_d.evt_cnt), 32'h2);
    cyc(8'h10, 8'hFF, 8'h00, 1'b0, 1'b1);
    chk("midrst_pending", 32'(if_d.pending), 32'h00);
    chk("midrst_y",       32'(if_d.y),       32'h0);
    chk("midrst_cnt",     32'(if_d.evt_cnt), 32'h0);

    // ---- random traffic, checked every cycle by the compare process ----
    for (int i = 0; i < 600; i++) begin
      cyc(8'($urandom), 8'($urandom),
          ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 63) == 0));
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_irq_or_agg
`default_nettype wire
